// File: rtl/hit_judge.sv
// Rhythm-game hit judge: debounces a push key, grades presses against a 4-slot note window,
// and keeps saturating score / combo / max-combo counters.
module hit_judge #(
  parameter int unsigned DEBOUNCE_CYCLES = 250000,
  parameter int unsigned SCORE_MAX       = 255
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic       load_n,
  input  logic       enable,
  input  logic       button_n,
  input  logic [3:0] window,
  output logic [3:0] clear_slot,
  output logic [7:0] score,
  output logic [7:0] combo,
  output logic [7:0] max_combo,
  output logic [1:0] accuracy,
  output logic       hit_pulse
);

  localparam int unsigned   CntW     = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(DEBOUNCE_CYCLES - 1);
  localparam logic [7:0]    ScoreMax = 8'(SCORE_MAX);

  typedef enum logic [1:0] {StIdle, StArmed, StJudge, StHeld} state_e;

  state_e            r_state;
  logic              r_sync1, r_sync2, r_stable, r_press, r_deferred;
  logic [CntW-1:0]   r_cnt;
  logic [7:0]        r_score, r_combo, r_max;
  logic [1:0]        r_acc;
  logic [3:0]        r_clear;
  logic              r_hit;

  logic              w_eval, w_perfect, w_good, w_hit, w_miss;
  logic [3:0]        w_clear;

  function automatic logic [7:0] sat_add(input logic [7:0] a, input logic [1:0] inc);
    logic [8:0] s;
    s = {1'b0, a} + {7'b0, inc};
    return (s > {1'b0, ScoreMax}) ? ScoreMax : s[7:0];
  endfunction

  // Synchronizer and debouncer; r_press pulses once on each accepted 1->0 change.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_sync1  <= 1'b1;
      r_sync2  <= 1'b1;
      r_stable <= 1'b1;
      r_cnt    <= '0;
      r_press  <= 1'b0;
    end else begin
      r_sync1 <= button_n;
      r_sync2 <= r_sync1;
      r_press <= 1'b0;
      if (r_sync2 == r_stable) begin
        r_cnt <= '0;
      end else if (r_cnt == CntLast) begin
        r_cnt    <= '0;
        r_stable <= r_sync2;
        r_press  <= ~r_sync2;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  // A tick during the first JUDGE cycle postpones grading to the post-shift window.
  always_comb begin
    w_eval    = enable && (r_state == StJudge) && !(tick && !r_deferred);
    w_perfect = w_eval && window[2];
    w_good    = w_eval && !window[2] && (window[1] || window[3]);
    w_hit     = w_perfect || w_good;
    w_miss    = tick && enable && window[0];
    w_clear   = 4'b0000;
    if (w_perfect)      w_clear = 4'b0100;
    else if (w_good)    w_clear = window[1] ? 4'b0010 : 4'b1000;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state    <= StIdle;
      r_deferred <= 1'b0;
      r_score    <= '0;
      r_combo    <= '0;
      r_max      <= '0;
      r_acc      <= 2'b00;
      r_clear    <= 4'b0000;
      r_hit      <= 1'b0;
    end else begin
      r_clear <= 4'b0000;
      r_hit   <= 1'b0;
      r_max   <= (r_combo > r_max) ? r_combo : r_max;
      if (!load_n) begin
        r_state    <= StIdle;
        r_deferred <= 1'b0;
        r_score    <= '0;
        r_combo    <= '0;
        r_max      <= '0;
        r_acc      <= 2'b00;
      end else begin
        if (w_hit) begin
          r_score <= sat_add(r_score, w_perfect ? 2'd2 : 2'd1);
          r_combo <= sat_add(r_combo, 2'd1);
          r_clear <= w_clear;
          r_hit   <= 1'b1;
          r_acc   <= w_perfect ? 2'b01 : 2'b10;
        end else if (w_eval) begin
          r_acc <= 2'b00;
        end
        // A miss overrides the combo/accuracy of a coincident hit but keeps its score.
        if (w_miss) begin
          r_combo <= '0;
          r_acc   <= 2'b11;
        end
        if (!enable) begin
          r_state    <= StIdle;
          r_deferred <= 1'b0;
        end else begin
          unique case (r_state)
            StIdle:  r_state <= StArmed;
            StArmed: begin
              r_deferred <= 1'b0;
              if (r_press) r_state <= StJudge;
            end
            StJudge: begin
              if (w_eval) r_state <= StHeld;
              else        r_deferred <= 1'b1;
            end
            StHeld:  if (r_stable) r_state <= StArmed;
          endcase
        end
      end
    end
  end

  assign score      = r_score;
  assign combo      = r_combo;
  assign max_combo  = r_max;
  assign accuracy   = r_acc;
  assign clear_slot = r_clear;
  assign hit_pulse  = r_hit;

endmodule

// File: doc/hit_judge.md
HIT_JUDGE -- requirements
Module: hit_judge

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 250000: consecutive identical synchronized samples needed to accept a new button level (5 ms at 50 MHz).
REQ-002 SHALL have parameter SCORE_MAX, default 255: saturation value for score, combo and max_combo.
REQ-003 SHALL have port clk  input  1  system clock (CLOCK_50), all logic on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port tick  input  1  one-clk pulse per note step; the note window shifts on this cycle.
REQ-006 SHALL have port load_n  input  1  active-low game restart from KEY[0].
REQ-007 SHALL have port enable  input  1  high while gameplay state is active.
REQ-008 SHALL have port button_n  input  1  raw asynchronous push key, low = pressed.
REQ-009 SHALL have port window  input  4  note shifter bits [3:0]: bit0 expired, bit1 early, bit2 centre, bit3 late.
REQ-010 SHALL have port clear_slot  output  4  one-clk pulse; a bit is set to make the shifter drop a consumed note.
REQ-011 SHALL have port score  output  8  accumulated score.
REQ-012 SHALL have port combo  output  8  current consecutive-hit count.
REQ-013 SHALL have port max_combo  output  8  highest combo since restart.
REQ-014 SHALL have port accuracy  output  2  last judgement: 00 none, 01 perfect, 10 good, 11 miss.
REQ-015 SHALL have port hit_pulse  output  1  one-clk pulse on each perfect/good judgement.

Function
REQ-016 button_n SHALL pass through a 2-flop synchronizer before any other use.
REQ-017 The debouncer SHALL change its stable level only after DEBOUNCE_CYCLES consecutive samples differ from it; any bounce SHALL restart the count.
REQ-018 A press event SHALL be a stable 1->0 transition; at most one press event per physical press.
REQ-019 FSM states: IDLE, ARMED, JUDGE, HELD. IDLE->ARMED when enable=1; any state->IDLE when enable=0 (pending press discarded).
REQ-020 ARMED->JUDGE on a press event; if tick=1 in the JUDGE cycle, the judgement SHALL be deferred one cycle so it uses the post-shift window.
REQ-021 JUDGE SHALL evaluate window for one clk, then go to HELD; HELD->ARMED on stable release (level 1).
REQ-022 Judgement priority: window[2] -> perfect (accuracy 01, score +2); else window[1] -> good (10, +1); else window[3] -> good (10, +1); else accuracy 00, score and combo unchanged.
REQ-023 On perfect/good: combo +1, corresponding clear_slot bit and hit_pulse high for exactly that cycle.
REQ-024 Miss: on any cycle with tick=1, enable=1 and window[0]=1 -> combo 0, accuracy 11, no clear_slot.
REQ-025 If a hit judgement and a miss fall in the same cycle: score add SHALL apply, combo SHALL be 0, accuracy SHALL be 11.
REQ-026 score, combo SHALL saturate at SCORE_MAX (no wrap); score+2 at SCORE_MAX-1 yields SCORE_MAX.
REQ-027 max_combo SHALL update on the cycle after combo exceeds it (registered compare, 1-clk latency).
REQ-028 load_n=0 SHALL clear score, combo, max_combo, accuracy, return FSM to IDLE; FSM leaves IDLE only after load_n=1.
REQ-029 clear_slot SHALL be 0 in every cycle not covered by REQ-023.

Reset
REQ-030 When rst=0 at a clk edge: score, combo, max_combo = 0; accuracy = 00; clear_slot = 0; hit_pulse = 0; FSM = IDLE; synchronizer and debouncer stable level = 1 (released), debounce counter = 0.
REQ-031 Reset SHALL win over load_n, tick and press events in the same cycle; a reset mid-press SHALL not produce a judgement after release of rst unless a new stable 1->0 transition occurs.

Verification (DEBOUNCE_CYCLES=4 override)
REQ-032 Clean press with window=0100, enable=1 -> accuracy 01, score 0->2, combo 0->1, clear_slot=0100 and hit_pulse for one clk.
REQ-033 Press bouncing 3 times (<4 cycles each) then held low -> exactly one judgement; holding 100 clks adds no further score.
REQ-034 tick with window=0001, combo=5 -> combo 0, accuracy 11, score unchanged.
REQ-035 score=254, perfect hit -> score 255; further hits keep 255; combo=255 + hit -> 255.
REQ-036 Press event coincident with tick -> judgement uses next-cycle window; window=1010 -> accuracy 10, clear_slot=0010.
REQ-037 load_n=0 after score=17, combo=9, max_combo=12 -> all 0, accuracy 00; rst=0 during HELD then release -> no judgement until new press.
